// File: rtl/shift_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_ctrl_pkg
//  Description : Shared types and constants for the shift-register control
//                unit. Holds the controller state encoding and the default
//                number of shift cycles issued per Execute request.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_ctrl_pkg;

    // Controller states. The explicit 2-bit base keeps the encoding stable
    // across tools and makes it visible on a waveform as 0/1/2.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } ctrl_state_t;

    // Shift cycles issued per Execute press unless overridden at the top.
    localparam int DEFAULT_N_SHIFTS = 8;

endpackage : shift_ctrl_pkg
`default_nettype wire

// File: rtl/shift_count.sv
`default_nettype none
// ============================================================================
//  Module      : shift_count
//  Description : Shift-cycle counter for the control unit. Cleared when a run
//                starts, advanced on every enabled shift cycle, and saturating
//                at N_SHIFTS so it can never wrap while the controller waits
//                in HOLD.
//  Ports       : Clk      in  system clock
//                Reset    in  asynchronous active-high reset (count -> 0)
//                Clear    in  synchronous clear, used on run start
//                Enable   in  advance the count this cycle
//                Terminal out high while the count equals N_SHIFTS-1, i.e.
//                             the current cycle is the last shift of a run
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_count
    import shift_ctrl_pkg::*;
#(
    parameter int N_SHIFTS = DEFAULT_N_SHIFTS,
    parameter int CNT_W    = $clog2(N_SHIFTS + 1)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Clear,
    input  logic Enable,
    output logic Terminal
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N_SHIFTS - 1);
    localparam logic [CNT_W-1:0] c_MAX  = CNT_W'(N_SHIFTS);

    logic [CNT_W-1:0] r_count;

    // Clear has priority over Enable; the count stops at N_SHIFTS, which
    // CNT_W is sized to hold, so a stray enable can never wrap it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (Clear) begin
            r_count <= '0;
        end else if (Enable && (r_count != c_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign Terminal = (r_count == c_LAST);

endmodule : shift_count
`default_nettype wire

// File: rtl/shift_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : shift_control_unit
//  Description : Control FSM for the dual 8-bit shift-register pair (A/B).
//                Converts LoadA/LoadB/Execute switch levels into Ld_A, Ld_B
//                and Shift_En strobes. One Execute press issues exactly
//                N_SHIFTS shift cycles, after which the unit waits in HOLD
//                until Execute is released.
//  Ports       : Clk      in  system clock
//                Reset    in  asynchronous active-high reset
//                Execute  in  run request (level, synchronised/debounced)
//                LoadA    in  load request for register A
//                LoadB    in  load request for register B
//                Step     in  single-step advance (SHIFT_CTRL_STEP_EN only)
//                Ld_A     out load strobe, register A
//                Ld_B     out load strobe, register B
//                Shift_En out shift strobe, both registers
//                Busy     out high while shifting
//                Done     out high while holding after a completed run
//  Config      : SHIFT_CTRL_STEP_EN - when defined, adds the Step port; in
//                SHIFT a shift (and count advance) happens only on cycles
//                with Step high. Undefined: shifts run every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_control_unit
    import shift_ctrl_pkg::*;
#(
    parameter int N_SHIFTS = DEFAULT_N_SHIFTS,
    parameter int CNT_W    = $clog2(N_SHIFTS + 1)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Execute,
    input  logic LoadA,
    input  logic LoadB,
`ifdef SHIFT_CTRL_STEP_EN
    input  logic Step,
`endif
    output logic Ld_A,
    output logic Ld_B,
    output logic Shift_En,
    output logic Busy,
    output logic Done
);

    ctrl_state_t r_state;

    logic w_step;      // shift qualifier for the current SHIFT cycle
    logic w_start;     // IDLE -> SHIFT transition this cycle
    logic w_count_en;  // a shift actually issues this cycle
    logic w_terminal;  // this shift is the last one of the run

`ifdef SHIFT_CTRL_STEP_EN
    assign w_step = Step;
`else
    assign w_step = 1'b1;
`endif

    // Loads take priority over Execute in IDLE, so a run only starts on a
    // cycle with both load requests low.
    assign w_start    = (r_state == IDLE) && !LoadA && !LoadB && Execute;
    assign w_count_en = (r_state == SHIFT) && w_step;

    shift_count #(
        .N_SHIFTS (N_SHIFTS),
        .CNT_W    (CNT_W)
    ) u_shift_count (
        .Clk      (Clk),
        .Reset    (Reset),
        .Clear    (w_start),
        .Enable   (w_count_en),
        .Terminal (w_terminal)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Execute is not looked at here: a started run always
                    // completes all of its shifts.
                    if (w_count_en && w_terminal) begin
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    // Leaving only on release means a held Execute can
                    // never start a second run.
                    if (!Execute) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode from the state register; the load strobes pass the
    // request straight through in IDLE. Everything is masked by Reset so the
    // strobes are quiet for the whole reset interval, regardless of inputs.
    assign Ld_A     = !Reset && (r_state == IDLE) && LoadA;
    assign Ld_B     = !Reset && (r_state == IDLE) && LoadB;
    assign Shift_En = !Reset && w_count_en;
    assign Busy     = !Reset && (r_state == SHIFT);
    assign Done     = !Reset && (r_state == HOLD);

endmodule : shift_control_unit
`default_nettype wire
